fnd_font_capture: RTL and testbench
===================================

Name: fnd_font_capture

Overview:
- Reverse path of the 7-segment font decoder used on the FND display.
- Monitors the multiplexed FND drive lines (active-low digit select and active-low font) and decodes each digit's font back to BCD.
- Assembles a complete 4-digit frame and presents it with a valid flag.
- Used as an on-chip self-check / loopback monitor of the display scanner, and as a readback source for the counter value shown on the FND.

Parameters:
SETTLE_CYCLES, 4, consecutive cycles that select and font must hold unchanged before a digit is captured (legal range 1..255).

Ports:
i_clk  input  1  system clock
i_reset  input  1  asynchronous, active-high reset
i_fndDigit  input  4  active-low digit select; 4'b1110=digit0 (ones) ... 4'b0111=digit3 (thousands)
i_fndFont  input  8  active-low segment pattern {dp,g,f,e,d,c,b,a}
o_value  output  16  captured BCD frame {digit3,digit2,digit1,digit0}
o_dp  output  4  captured decimal-point state per digit, 1=lit
o_valid  output  1  at least one complete frame captured since reset
o_fontErr  output  1  last completed frame contained an undecodable font
o_frameDone  output  1  one-cycle pulse when o_value is updated

Behaviour:
- Reset: one clock domain; reset is asynchronous and active-high on i_clk/i_reset.
  - All outputs go to 0: o_value=16'h0000, o_dp=0, o_valid=0, o_fontErr=0, o_frameDone=0.
  - Internal state returns to WAIT_SEL, seen-mask=0, shadow registers=0, stability counter=0.
  - Reset mid-frame discards all partial captures.
- Inputs are synchronous to i_clk; no synchronizers.
- Font decode (bit7 ignored, compared with bit7 forced to 1):
  - c0→0, f9→1, a4→2, b0→3, 99→4, 92→5, 82→6, f8→7, 80→8, 98→9.
  - Any other pattern → nibble 4'hF and sets the frame error flag.
  - dp lit when i_fndFont[7]=0.
- Valid select = exactly one bit of i_fndDigit low. All-high or multiple-low selects are invalid.
- State machine:
  - WAIT_SEL: stays while the select is invalid. On a valid select → SETTLE, counter=1.
  - SETTLE:
    - Each cycle, if i_fndDigit and i_fndFont equal their previous-cycle values, counter increments; if the font changed, counter=1; if the select changed to another valid digit, counter=1 for the new digit; if the select became invalid → WAIT_SEL.
    - When the counter reaches SETTLE_CYCLES, capture happens on that clock edge → CAPTURED.
  - CAPTURED: holds while inputs are unchanged. On a select change → SETTLE (valid) or WAIT_SEL (invalid). A font change with the same select → SETTLE, counter=1, allowing recapture.
- Capture: writes the decoded nibble, dp bit and error bit into the digit's shadow slot and sets that seen-mask bit. Recapturing an already-seen digit overwrites the slot; the mask is unchanged.
- Frame completion: on the edge where a capture makes seen-mask=4'b1111:
  - o_value/o_dp are loaded from the shadow including the current capture.
  - o_fontErr = OR of the four error bits.
  - o_frameDone=1 for exactly one cycle; o_valid=1 (sticky until reset).
  - seen-mask and error bits are cleared.
- Latency: with the select and font presented from cycle 0, the capture edge is the end of cycle SETTLE_CYCLES-1. A completed frame is visible in cycle SETTLE_CYCLES.
- Between frames o_value holds the last complete frame; partial frames are never visible.
- Digit order is irrelevant; any permutation of the four digits completes a frame.

Test Plan:
- Reset then scan digits 0..3 with fonts f9,a4,b0,99, each held 8 cycles → one o_frameDone pulse after the 4th capture, o_value=16'h4321, o_valid=1, o_fontErr=0, o_dp=0.
- Digit0 held exactly SETTLE_CYCLES-1=3 cycles, then a switch to digit1 → no capture of digit0. The frame completes only after digit0 is later held ≥4 cycles; frameDone is checked on the exact cycle.
- Font glitch: digit2 select held 10 cycles with font 82 for 2 cycles, then 80 → captured nibble 8 (the glitch restarts the count); frame value 16'h?8??, with the other digits driven 0 → 16'h0800.
- Invalid font 8'hff on digit3 plus dp (8'h40 pattern with bit7=0 on digit1) → o_value[15:12]=F, o_fontErr=1, o_dp=4'b0010. The next clean frame clears o_fontErr.
- Select 4'b1111 and 4'b1100 mid-scan → no capture, state WAIT_SEL, seen-mask retained. Completing the remaining digits yields a frame.
- Assert i_reset with 3 of 4 digits captured → all outputs 0 immediately (asynchronous). After release, only a full new 4-digit scan produces o_frameDone.

Source files
------------

// File: rtl/fnd_font_capture_if.sv
// FND drive lines plus captured-frame readback, bundled between the display
// scanner side (master) and the capture monitor (slave).
interface fnd_font_capture_if;
  logic [3:0]  i_fndDigit;   // active-low digit select
  logic [7:0]  i_fndFont;    // active-low {dp,g,f,e,d,c,b,a}
  logic [15:0] o_value;      // {digit3,digit2,digit1,digit0} BCD
  logic [3:0]  o_dp;         // decimal point per digit, 1=lit
  logic        o_valid;      // a full frame has been captured since reset
  logic        o_fontErr;    // last frame held an undecodable font
  logic        o_frameDone;  // one-cycle pulse on o_value update

  modport master (
    output i_fndDigit, i_fndFont,
    input  o_value, o_dp, o_valid, o_fontErr, o_frameDone
  );

  modport slave (
    input  i_fndDigit, i_fndFont,
    output o_value, o_dp, o_valid, o_fontErr, o_frameDone
  );
endinterface

// File: rtl/fnd_font_capture.sv
// Reverse 7-segment decoder: watches the multiplexed FND drive, waits for each
// digit's select/font to settle, decodes it back to BCD and publishes only
// complete 4-digit frames.
module fnd_font_capture #(
  parameter int SETTLE_CYCLES = 4  // 1..255
) (
  input  logic               i_clk,
  input  logic               i_reset,
  fnd_font_capture_if.slave  bus
);

  typedef enum logic [1:0] {WAIT_SEL, SETTLE, CAPTURED} state_t;

  localparam logic [7:0] SETTLE_N = 8'(SETTLE_CYCLES);

  state_t          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [3:0]      prev_dig_q;
  logic [7:0]      prev_font_q;

  // Shadow of the frame being assembled; never visible until complete.
  logic [3:0]      seen_q, seen_d;
  logic [3:0]      err_q;
  logic [3:0][3:0] nib_q;
  logic [3:0]      sdp_q;

  logic [15:0]     value_q;
  logic [3:0]      dp_q;
  logic            valid_q, fontErr_q, frameDone_q;

  logic            sel_ok;
  logic [1:0]      sel_idx;
  logic [3:0]      nib_c;
  logic            err_c, dp_c;
  logic            cap;
  logic            same_in;
  logic [3:0][3:0] frame_nib;
  logic [3:0]      frame_dp, frame_err;
  logic            frame_done;

  // Exactly one select line low picks a digit; anything else is idle/invalid.
  always_comb begin
    sel_ok  = 1'b1;
    sel_idx = 2'd0;
    case (bus.i_fndDigit)
      4'b1110: sel_idx = 2'd0;
      4'b1101: sel_idx = 2'd1;
      4'b1011: sel_idx = 2'd2;
      4'b0111: sel_idx = 2'd3;
      default: sel_ok  = 1'b0;
    endcase
  end

  // Font back to BCD; the dp bit is masked off so it never affects the digit.
  always_comb begin
    nib_c = 4'hF;
    err_c = 1'b0;
    case ({1'b1, bus.i_fndFont[6:0]})
      8'hc0:   nib_c = 4'd0;
      8'hf9:   nib_c = 4'd1;
      8'ha4:   nib_c = 4'd2;
      8'hb0:   nib_c = 4'd3;
      8'h99:   nib_c = 4'd4;
      8'h92:   nib_c = 4'd5;
      8'h82:   nib_c = 4'd6;
      8'hf8:   nib_c = 4'd7;
      8'h80:   nib_c = 4'd8;
      8'h98:   nib_c = 4'd9;
      default: err_c = 1'b1;
    endcase
  end

  assign dp_c    = ~bus.i_fndFont[7];
  assign same_in = (bus.i_fndDigit == prev_dig_q) && (bus.i_fndFont == prev_font_q);

  // Settle tracking: any change of select or font restarts the count at 1, and
  // the capture fires on the edge where the count would reach SETTLE_CYCLES.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap     = 1'b0;
    case (state_q)
      WAIT_SEL: begin
        if (sel_ok) begin
          state_d = SETTLE;
          cnt_d   = 8'd1;
        end
      end
      SETTLE: begin
        if (!sel_ok) begin
          state_d = WAIT_SEL;
          cnt_d   = 8'd0;
        end else if (!same_in) begin
          cnt_d   = 8'd1;
        end else begin
          cnt_d   = cnt_q + 8'd1;
        end
      end
      CAPTURED: begin
        if (!sel_ok) begin
          state_d = WAIT_SEL;
          cnt_d   = 8'd0;
        end else if (!same_in) begin
          state_d = SETTLE;
          cnt_d   = 8'd1;
        end
      end
      default: begin
        state_d = WAIT_SEL;
        cnt_d   = 8'd0;
      end
    endcase
    // Checked after the transition so a restart can capture at once when
    // SETTLE_CYCLES is 1.
    if (state_d == SETTLE && cnt_d == SETTLE_N) begin
      cap     = 1'b1;
      state_d = CAPTURED;
    end
  end

  // Frame view including the digit being captured this cycle.
  always_comb begin
    seen_d             = seen_q | (4'b0001 << sel_idx);
    frame_nib          = nib_q;
    frame_nib[sel_idx] = nib_c;
    frame_dp           = sdp_q;
    frame_dp[sel_idx]  = dp_c;
    frame_err          = err_q;
    frame_err[sel_idx] = err_c;
    frame_done         = cap && (&seen_d);
  end

  // FSM, shadow slots and published frame registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= WAIT_SEL;
      cnt_q        <= 8'd0;
      prev_dig_q   <= 4'd0;
      prev_font_q  <= 8'd0;
      seen_q       <= 4'd0;
      err_q        <= 4'd0;
      nib_q        <= '0;
      sdp_q        <= 4'd0;
      value_q      <= 16'h0000;
      dp_q         <= 4'd0;
      valid_q      <= 1'b0;
      fontErr_q    <= 1'b0;
      frameDone_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      prev_dig_q   <= bus.i_fndDigit;
      prev_font_q  <= bus.i_fndFont;
      frameDone_q  <= 1'b0;
      if (cap) begin
        nib_q[sel_idx] <= nib_c;
        sdp_q[sel_idx] <= dp_c;
        if (frame_done) begin
          seen_q      <= 4'd0;
          err_q       <= 4'd0;
          value_q     <= frame_nib;
          dp_q        <= frame_dp;
          fontErr_q   <= |frame_err;
          frameDone_q <= 1'b1;
          valid_q     <= 1'b1;
        end else begin
          seen_q         <= seen_d;
          err_q[sel_idx] <= err_c;
        end
      end
    end
  end

  assign bus.o_value     = value_q;
  assign bus.o_dp        = dp_q;
  assign bus.o_valid     = valid_q;
  assign bus.o_fontErr   = fontErr_q;
  assign bus.o_frameDone = frameDone_q;

endmodule

// File: tb/tb_fnd_font_capture.sv
// Bench for fnd_font_capture: decode table, hand-written corner sequences and
// randomized scans, all compared every cycle against a run-length model.
module tb_fnd_font_capture;
  localparam int S = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fnd_font_capture_if bus();

  fnd_font_capture #(.SETTLE_CYCLES(S)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  int done_total = 0;

  logic [7:0] FONTS [10] = '{8'hc0, 8'hf9, 8'ha4, 8'hb0, 8'h99,
                             8'h92, 8'h82, 8'hf8, 8'h80, 8'h98};

  // Reference: a digit is captured when the same valid (select,font) pair has
  // been seen for exactly S consecutive cycles.
  int         run_len;
  logic [3:0] run_sel;
  logic [7:0] run_font;
  logic [3:0] m_nib [4];
  logic       m_dp  [4];
  logic       m_err [4];
  logic       m_seen[4];
  logic [15:0] m_value;
  logic [3:0]  m_dpo;
  logic        m_valid, m_ferr, m_done;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int sel_index(input logic [3:0] s);
    int zeros = 0;
    int pos = -1;
    for (int i = 0; i < 4; i++) if (!s[i]) begin zeros++; pos = i; end
    return (zeros == 1) ? pos : -1;
  endfunction

  function automatic logic [4:0] decode(input logic [7:0] f);
    logic [7:0] g = f | 8'h80;
    for (int k = 0; k < 10; k++) if (FONTS[k] == g) return {1'b0, 4'(k)};
    return 5'h1F;
  endfunction

  task automatic model_reset();
    run_len = 0; run_sel = '0; run_font = '0;
    for (int i = 0; i < 4; i++) begin
      m_nib[i] = '0; m_dp[i] = 0; m_err[i] = 0; m_seen[i] = 0;
    end
    m_value = '0; m_dpo = '0; m_valid = 0; m_ferr = 0; m_done = 0;
  endtask

  task automatic model_edge(input logic [3:0] d, input logic [7:0] f);
    int ix;
    logic [4:0] dec;
    m_done = 0;
    ix = sel_index(d);
    if (ix < 0) run_len = 0;
    else if (run_len > 0 && d == run_sel && f == run_font) run_len++;
    else begin run_sel = d; run_font = f; run_len = 1; end
    if (ix >= 0 && run_len == S) begin
      dec = decode(f);
      m_nib[ix] = dec[3:0]; m_dp[ix] = ~f[7]; m_err[ix] = dec[4]; m_seen[ix] = 1;
      if (m_seen[0] && m_seen[1] && m_seen[2] && m_seen[3]) begin
        m_value = {m_nib[3], m_nib[2], m_nib[1], m_nib[0]};
        m_dpo   = {m_dp[3], m_dp[2], m_dp[1], m_dp[0]};
        m_ferr  = m_err[0] | m_err[1] | m_err[2] | m_err[3];
        m_done  = 1; m_valid = 1;
        for (int i = 0; i < 4; i++) begin m_seen[i] = 0; m_err[i] = 0; end
      end
    end
  endtask

  task automatic step(input logic [3:0] d, input logic [7:0] f);
    bus.i_fndDigit = d;
    bus.i_fndFont  = f;
    @(posedge clk);
    model_edge(d, f);
    #1;
    chk("value", bus.o_value, m_value);
    chk("dp", bus.o_dp, m_dpo);
    chk("valid", bus.o_valid, m_valid);
    chk("fontErr", bus.o_fontErr, m_ferr);
    chk("frameDone", bus.o_frameDone, m_done);
    if (bus.o_frameDone) done_total++;
  endtask

  task automatic hold(input logic [3:0] d, input logic [7:0] f, input int n, output int done_at);
    done_at = 0;
    for (int i = 0; i < n; i++) begin
      step(d, f);
      if (bus.o_frameDone) done_at = i + 1;
    end
  endtask

  typedef struct {
    logic [7:0] font;
    logic [3:0] nib;
    logic       dp;
    logic       err;
  } vec_t;

  vec_t vecs [14];

  initial begin
    int da;
    vecs = '{
      '{8'hc0, 4'd0, 1'b0, 1'b0}, '{8'hf9, 4'd1, 1'b0, 1'b0},
      '{8'ha4, 4'd2, 1'b0, 1'b0}, '{8'hb0, 4'd3, 1'b0, 1'b0},
      '{8'h99, 4'd4, 1'b0, 1'b0}, '{8'h92, 4'd5, 1'b0, 1'b0},
      '{8'h82, 4'd6, 1'b0, 1'b0}, '{8'hf8, 4'd7, 1'b0, 1'b0},
      '{8'h80, 4'd8, 1'b0, 1'b0}, '{8'h98, 4'd9, 1'b0, 1'b0},
      '{8'h19, 4'd4, 1'b1, 1'b0}, '{8'h00, 4'd8, 1'b1, 1'b0},
      '{8'hff, 4'hF, 1'b0, 1'b1}, '{8'h7f, 4'hF, 1'b1, 1'b1}
    };

    rst = 1'b1;
    bus.i_fndDigit = 4'hF;
    bus.i_fndFont  = 8'hFF;
    model_reset();
    #12;
    chk("rst_value", bus.o_value, 16'h0000);
    chk("rst_dp", bus.o_dp, 4'h0);
    chk("rst_valid", bus.o_valid, 1'b0);
    chk("rst_fontErr", bus.o_fontErr, 1'b0);
    chk("rst_frameDone", bus.o_frameDone, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Basic scan 0..3.
    done_total = 0;
    hold(4'b1110, 8'hf9, 8, da);
    hold(4'b1101, 8'ha4, 8, da);
    hold(4'b1011, 8'hb0, 8, da);
    hold(4'b0111, 8'h99, 8, da);
    chk("scan_done_at", da, 4);
    chk("scan_pulses", done_total, 1);
    chk("scan_value", bus.o_value, 16'h4321);
    chk("scan_valid", bus.o_valid, 1'b1);
    chk("scan_fontErr", bus.o_fontErr, 1'b0);
    chk("scan_dp", bus.o_dp, 4'h0);

    // Digit0 held one cycle short: no capture until held long enough.
    done_total = 0;
    hold(4'b1110, 8'hf8, S - 1, da);
    hold(4'b1101, 8'h92, 8, da);
    hold(4'b1011, 8'h82, 8, da);
    hold(4'b0111, 8'h98, 8, da);
    chk("short_no_frame", done_total, 0);
    chk("short_value_held", bus.o_value, 16'h4321);
    hold(4'b1110, 8'hf8, 8, da);
    chk("short_done_at", da, 4);
    chk("short_value", bus.o_value, 16'h9657);

    // Font glitch on digit2 restarts the settle count.
    hold(4'b1110, 8'hc0, 8, da);
    hold(4'b1101, 8'hc0, 8, da);
    hold(4'b1011, 8'h82, 2, da);
    hold(4'b1011, 8'h80, 8, da);
    hold(4'b0111, 8'hc0, 8, da);
    chk("glitch_done_at", da, 4);
    chk("glitch_value", bus.o_value, 16'h0800);

    // Undecodable font and a lit dp, then a clean frame clears the error.
    hold(4'b1110, 8'hc0, 8, da);
    hold(4'b1101, 8'h40, 8, da);
    hold(4'b1011, 8'hc0, 8, da);
    hold(4'b0111, 8'hff, 8, da);
    chk("err_value", bus.o_value, 16'hF000);
    chk("err_fontErr", bus.o_fontErr, 1'b1);
    chk("err_dp", bus.o_dp, 4'b0010);
    hold(4'b1110, 8'hc0, 8, da);
    hold(4'b1101, 8'hc0, 8, da);
    hold(4'b1011, 8'hc0, 8, da);
    hold(4'b0111, 8'hc0, 8, da);
    chk("clean_fontErr", bus.o_fontErr, 1'b0);
    chk("clean_value", bus.o_value, 16'h0000);
    chk("clean_dp", bus.o_dp, 4'h0);

    // Invalid selects mid-scan keep the partial frame.
    done_total = 0;
    hold(4'b1110, 8'hf9, 8, da);
    hold(4'b1101, 8'ha4, 8, da);
    hold(4'b1111, 8'hc0, 5, da);
    hold(4'b1100, 8'hc0, 5, da);
    hold(4'b1011, 8'hb0, 8, da);
    chk("inv_no_frame", done_total, 0);
    hold(4'b0111, 8'h99, 8, da);
    chk("inv_done_at", da, 4);
    chk("inv_value", bus.o_value, 16'h4321);

    // Asynchronous reset with three digits captured.
    hold(4'b1110, 8'h98, 8, da);
    hold(4'b1101, 8'h98, 8, da);
    hold(4'b1011, 8'h98, 8, da);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("arst_value", bus.o_value, 16'h0000);
    chk("arst_valid", bus.o_valid, 1'b0);
    chk("arst_dp", bus.o_dp, 4'h0);
    chk("arst_fontErr", bus.o_fontErr, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    done_total = 0;
    hold(4'b0111, 8'h99, 8, da);
    chk("arst_partial", done_total, 0);
    chk("arst_valid_low", bus.o_valid, 1'b0);
    hold(4'b1110, 8'hf9, 8, da);
    hold(4'b1101, 8'ha4, 8, da);
    hold(4'b1011, 8'hb0, 8, da);
    chk("arst_done_at", da, 4);
    chk("arst_value_new", bus.o_value, 16'h4321);

    // Decode table: digits 1..3 drive 0, digit0 under test completes the frame.
    foreach (vecs[k]) begin
      hold(4'b1101, 8'hc0, 5, da);
      hold(4'b1011, 8'hc0, 5, da);
      hold(4'b0111, 8'hc0, 5, da);
      hold(4'b1110, vecs[k].font, 5, da);
      chk("tbl_done_at", da, 4);
      chk("tbl_value", bus.o_value, {12'h000, vecs[k].nib});
      chk("tbl_dp", bus.o_dp, {3'b000, vecs[k].dp});
      chk("tbl_fontErr", bus.o_fontErr, vecs[k].err);
    end

    // Randomized scanning, including invalid selects and short holds.
    for (int n = 0; n < 250; n++) begin
      logic [3:0] d;
      logic [7:0] f;
      int r;
      r = $urandom_range(0, 9);
      if (r < 8)       d = ~(4'b0001 << (r % 4));
      else if (r == 8) d = 4'hF;
      else             d = 4'($urandom);
      r = $urandom_range(0, 9);
      if (r < 8) f = FONTS[$urandom_range(0, 9)] & {1'($urandom), 7'h7f};
      else       f = 8'($urandom);
      hold(d, f, $urandom_range(1, 7), da);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
